wb_commit_sched: RTL and testbench
==================================

// Module: wb_commit_sched
// PURPOSE
//  Schedules NUM_REQS commit streams (ld/fpu/alu/bitmanip/csr/gpu) onto the single
//  register-file writeback port. Fixed priority (index 0 highest) with an aging
//  escape that bounds the wait of any requester. Output is registered, so ready_in
//  never depends combinationally on a deep downstream path. Sits between the
//  execute-unit commit interfaces and the writeback pipe register.
// PARAMETERS
//  NUM_REQS      5   number of commit requesters (2..8)
//  DATAW         64  payload width per requester {wid,PC,tmask,rd,data,eop}
//  STARVE_LIMIT  15  wait cycles before a requester is promoted to starving (1..255)
//  CNTW          $clog2(STARVE_LIMIT+1)  derived; wait counter width
// PORTS
//  clk            in   1                 core clock
//  reset          in   1                 asynchronous, active-low reset (asserted at 0)
//  valid_in       in   NUM_REQS          per-requester beat valid
//  data_in        in   NUM_REQS*DATAW    per-requester payload, req i at [i*DATAW +: DATAW]
//  ready_in       out  NUM_REQS          one-hot grant; beat i accepted when valid_in[i]&ready_in[i]
//  valid_out      out  1                 registered beat valid toward writeback
//  data_out       out  DATAW             registered payload
//  sel_idx        out  $clog2(NUM_REQS)  source index of current data_out beat
//  ready_out      in   1                 writeback consumer ready
// BEHAVIOUR
//  - Reset (reset=0, async): valid_out=0, data_out=0, sel_idx=0, all wait_cnt=0;
//    ready_in=0 while reset asserted. Reset mid-operation discards held beat.
//  - can_load = ~valid_out | ready_out. ready_in=0 when ~can_load.
//  - Grant (comb., when can_load): if any i has valid_in[i] && wait_cnt[i]==STARVE_LIMIT,
//    grant lowest such i; else grant lowest i with valid_in[i]. At most one bit set.
//  - wait_cnt[i] per edge: 0 if ~valid_in[i] or granted; else +1 saturating at
//    STARVE_LIMIT (counts while backpressured too).
//  - Output reg: on grant load data_in[g], sel_idx=g, valid_out=1 (latency 1 cycle).
//    Else if valid_out&ready_out: valid_out=0 (data_out/sel_idx hold).
//    Simultaneous drain+grant: back-to-back, no bubble; throughput 1 beat/cycle.
//  - valid_out, data_out, sel_idx stable while valid_out&~ready_out.
//  - Requesters hold valid_in/data_in until accepted; dropping valid early is legal
//    and only clears that requester's wait_cnt.
//  - Worst-case wait bounded: STARVE_LIMIT + NUM_REQS-1 grant opportunities.
// CONFIGURATION
//  WB_SCHED_PERF_EN defined: adds outputs perf_stall_cycles[43:0] (cycles with
//    valid_out&~ready_out) and perf_starve_grants[31:0] (grants issued via aging path);
//    both 0 on reset, wrap on overflow.
//  Undefined: ports and counters absent; scheduling behaviour identical.
// TESTING
//  1 reset=0 with all valid_in=1 -> ready_in=0, valid_out=0; release -> first grant req0.
//  2 valid_in=5'b10110 held, ready_out=1, new beats each accept -> grants 1,1,1...;
//    valid_out cycle after first accept, sel_idx=1.
//  3 STARVE_LIMIT=3, req0,req4 always valid, ready_out=1 -> grant seq 0,0,0,4,0,0,0,4.
//  4 valid_out=1, ready_out=0 for 6 cycles, req2 valid -> ready_in=0, data_out stable;
//    ready_out=1 -> req2 granted same cycle, no bubble on valid_out.
//  5 single req3 beat 0xDEAD, ready_out=1 -> valid_out 1 cycle later, data_out=0xDEAD,
//    next cycle valid_out=0.
//  6 WB_SCHED_PERF_EN: hold ready_out=0 10 cycles with valid_out=1 -> perf_stall_cycles=10;
//    scenario 3 over 8 grants -> perf_starve_grants=2.

Source files
------------

// File: rtl/wb_commit_sched.sv
// wb_commit_sched: fixed-priority writeback scheduler with aging escape and a registered output beat.
// Define WB_SCHED_PERF_EN to add the stall and starve-grant performance counters.
module wb_commit_sched #(
    parameter int NUM_REQS     = 5,
    parameter int DATAW        = 64,
    parameter int STARVE_LIMIT = 15,
    localparam int CNTW        = $clog2(STARVE_LIMIT + 1),
    localparam int IDXW        = $clog2(NUM_REQS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       valid_in,
    input  logic [NUM_REQS*DATAW-1:0] data_in,
    output logic [NUM_REQS-1:0]       ready_in,
    output logic                      valid_out,
    output logic [DATAW-1:0]          data_out,
    output logic [IDXW-1:0]           sel_idx,
    input  logic                      ready_out
`ifdef WB_SCHED_PERF_EN
    ,
    output logic [43:0]               perf_stall_cycles,
    output logic [31:0]               perf_starve_grants
`endif
);
    logic                can_load;
    logic                any_starve;
    logic [NUM_REQS-1:0] starve;
    logic [NUM_REQS-1:0] pick;
    logic [IDXW-1:0]     gidx;
    logic [CNTW-1:0]     wait_cnt [NUM_REQS];

    // Starving requesters override plain priority; lowest index wins within either set.
    always_comb begin
        can_load = ~valid_out | ready_out;
        starve = '0;
        for (int i = 0; i < NUM_REQS; i++)
            starve[i] = valid_in[i] && (wait_cnt[i] == CNTW'(STARVE_LIMIT));
        any_starve = |starve;
        pick = any_starve ? starve : valid_in;
        gidx = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--)
            if (pick[i]) gidx = IDXW'(i);
        ready_in = '0;
        if (reset && can_load && |pick) ready_in[gidx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQS; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQS; i++)
                wait_cnt[i] <= (!valid_in[i] || ready_in[i]) ? '0 :
                               (wait_cnt[i] == CNTW'(STARVE_LIMIT)) ? wait_cnt[i] : wait_cnt[i] + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            sel_idx   <= '0;
        end else if (|ready_in) begin
            valid_out <= 1'b1;
            data_out  <= data_in[int'(gidx)*DATAW +: DATAW];
            sel_idx   <= gidx;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

`ifdef WB_SCHED_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles  <= '0;
            perf_starve_grants <= '0;
        end else begin
            if (valid_out && !ready_out) perf_stall_cycles <= perf_stall_cycles + 44'd1;
            if (|ready_in && any_starve) perf_starve_grants <= perf_starve_grants + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_wb_commit_sched.sv
// tb_wb_commit_sched: scoreboard bench for wb_commit_sched; directed grant sequences with hand-computed results.
module tb_wb_commit_sched;
    localparam int N  = 5;
    localparam int W  = 64;
    localparam int SL = 3;

    typedef struct packed {
        logic [2:0]   idx;
        logic [W-1:0] data;
    } beat_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   valid_in = '0;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   ready_in;
    logic           valid_out;
    logic [W-1:0]   data_out;
    logic [2:0]     sel_idx;
    logic           ready_out = 1'b0;
`ifdef WB_SCHED_PERF_EN
    logic [43:0]    perf_stall_cycles;
    logic [31:0]    perf_starve_grants;
`endif

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    beat_n[N];

    wb_commit_sched #(.NUM_REQS(N), .DATAW(W), .STARVE_LIMIT(SL)) dut (
        .clk(clk),
        .reset(reset),
        .valid_in(valid_in),
        .data_in(data_in),
        .ready_in(ready_in),
        .valid_out(valid_out),
        .data_out(data_out),
        .sel_idx(sel_idx),
        .ready_out(ready_out)
`ifdef WB_SCHED_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_starve_grants(perf_starve_grants)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(int i, int n);
        return (64'(i + 1) << 56) | 64'(n);
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Called at posedge+1: drives one cycle, checks the grant, queues the beat it should produce.
    task automatic step(input logic [N-1:0] v, input logic ro, input logic [N-1:0] eg, input string nm);
        int g;
        valid_in = v;
        ready_out = ro;
        #1;
        chk(nm, W'(ready_in), W'(eg));
        g = -1;
        for (int i = 0; i < N; i++) if (eg[i]) g = i;
        if (g >= 0) exp_q.push_back('{idx: 3'(g), data: data_in[g*W +: W]});
        @(posedge clk);
        #1;
        if (g >= 0) begin
            beat_n[g]++;
            data_in[g*W +: W] = mk(g, beat_n[g]);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (reset && valid_out && ready_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got sel %0d data %h, required no beat", sel_idx, data_out);
            end else begin
                e = exp_q.pop_front();
                chk("beat_idx", W'(sel_idx), W'(e.idx));
                chk("beat_data", data_out, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] hv;
        logic [W-1:0] nv;
        for (int i = 0; i < N; i++) begin
            beat_n[i] = 0;
            data_in[i*W +: W] = mk(i, 0);
        end
        valid_in = '1;
        ready_out = 1'b1;
        #2;
        chk("rst_ready_in", W'(ready_in), 0);
        chk("rst_valid_out", W'(valid_out), 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_sel_idx", W'(sel_idx), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(5'b11111, 1'b1, 5'b00001, "s1_grant0");
        chk("s1_valid_out", W'(valid_out), 1);
        chk("s1_sel_idx", W'(sel_idx), 0);
        step(5'b00000, 1'b1, 5'b00000, "s1_idle");
        chk("s1_valid_clear", W'(valid_out), 0);

        // 10110 held: req1 wins until req2 and req4 age out at SL
        step(5'b10110, 1'b1, 5'b00010, "s2_g1a");
        chk("s2_valid_out", W'(valid_out), 1);
        chk("s2_sel_idx", W'(sel_idx), 1);
        step(5'b10110, 1'b1, 5'b00010, "s2_g1b");
        step(5'b10110, 1'b1, 5'b00010, "s2_g1c");
        step(5'b10110, 1'b1, 5'b00100, "s2_age2");
        step(5'b10110, 1'b1, 5'b10000, "s2_age4");
        step(5'b00000, 1'b1, 5'b00000, "s2_idle");
`ifdef WB_SCHED_PERF_EN
        chk("s2_perf_starve", W'(perf_starve_grants), 2);
`endif

        for (int k = 0; k < 8; k++)
            step(5'b10001, 1'b1, (k % 4 == 3) ? 5'b10000 : 5'b00001, "s3_grant");
        step(5'b00000, 1'b1, 5'b00000, "s3_idle");
`ifdef WB_SCHED_PERF_EN
        chk("s3_perf_starve", W'(perf_starve_grants), 4);
`endif

        hv = data_in[2*W +: W];
        step(5'b00100, 1'b1, 5'b00100, "s4_load");
        for (int k = 0; k < 6; k++) begin
            step(5'b00100, 1'b0, 5'b00000, "s4_stall_ready_in");
            chk("s4_stall_valid", W'(valid_out), 1);
            chk("s4_stall_data", data_out, hv);
            chk("s4_stall_sel", W'(sel_idx), 2);
        end
        nv = data_in[2*W +: W];
        step(5'b00100, 1'b1, 5'b00100, "s4_resume");
        chk("s4_no_bubble", W'(valid_out), 1);
        chk("s4_new_data", data_out, nv);
        step(5'b00000, 1'b1, 5'b00000, "s4_idle");
        chk("s4_valid_clear", W'(valid_out), 0);
`ifdef WB_SCHED_PERF_EN
        chk("s4_perf_stall", W'(perf_stall_cycles), 6);
        chk("s4_perf_starve", W'(perf_starve_grants), 5);
`endif

        data_in[3*W +: W] = 64'hDEAD;
        step(5'b01000, 1'b1, 5'b01000, "s5_grant3");
        chk("s5_valid_out", W'(valid_out), 1);
        chk("s5_data_out", data_out, 64'hDEAD);
        chk("s5_sel_idx", W'(sel_idx), 3);
        step(5'b00000, 1'b1, 5'b00000, "s5_idle");
        chk("s5_valid_clear", W'(valid_out), 0);
        chk("s5_data_hold", data_out, 64'hDEAD);

        step(5'b00010, 1'b0, 5'b00010, "s6_load");
        chk("s6_valid_held", W'(valid_out), 1);
        reset = 1'b0;
        #1;
        chk("s6_rst_valid", W'(valid_out), 0);
        chk("s6_rst_data", data_out, 0);
        chk("s6_rst_ready_in", W'(ready_in), 0);
`ifdef WB_SCHED_PERF_EN
        chk("s6_rst_perf_stall", W'(perf_stall_cycles), 0);
`endif
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(5'b00000, 1'b1, 5'b00000, "s6_idle");
        chk("s6_valid_after", W'(valid_out), 0);

        repeat (3) @(posedge clk);
        chk("queue_empty", W'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
